// File: rtl/ysyx_23060191_wb_arbiter.sv
// ysyx_23060191_wb_arbiter: round-robin write-back arbiter merging EXU and LSU results into the register file
module ysyx_23060191_wb_arbiter #(
  parameter int CPU_WIDTH = 32,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exu_valid,
  output logic                 exu_ready,
  input  logic [REG_AW-1:0]    exu_rd,
  input  logic [CPU_WIDTH-1:0] exu_res,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_AW-1:0]    lsu_rd,
  input  logic [CPU_WIDTH-1:0] lsu_res,
  input  logic                 flush,
  output logic                 rf_wen,
  output logic [REG_AW-1:0]    rf_waddr,
  output logic [CPU_WIDTH-1:0] rf_wdata,
  output logic                 wb_src,
  output logic [31:0]          wb_cnt
);
  logic                 r_exu_full, r_lsu_full, r_last_lsu, r_wen, r_src;
  logic [REG_AW-1:0]    r_exu_rd, r_lsu_rd, r_waddr;
  logic [CPU_WIDTH-1:0] r_exu_res, r_lsu_res, r_wdata;
  logic [31:0]          r_wb_cnt;
  logic                 w_gnt_lsu, w_gnt_exu, w_gnt, w_wr, w_exu_hs, w_lsu_hs;
  logic [REG_AW-1:0]    w_rd;
  logic [CPU_WIDTH-1:0] w_res;
  // LSU wins a tie unless it was the last channel granted; flush suppresses all grants
  assign w_gnt_lsu = !flush && r_lsu_full && (!r_exu_full || !r_last_lsu);
  assign w_gnt_exu = !flush && r_exu_full && !w_gnt_lsu;
  assign w_gnt     = w_gnt_lsu || w_gnt_exu;
  assign w_rd      = w_gnt_lsu ? r_lsu_rd : r_exu_rd;
  assign w_res     = w_gnt_lsu ? r_lsu_res : r_exu_res;
  assign w_wr      = w_gnt && (w_rd != '0);
  assign exu_ready = !rst && !flush && (!r_exu_full || w_gnt_exu);
  assign lsu_ready = !rst && !flush && (!r_lsu_full || w_gnt_lsu);
  assign w_exu_hs  = exu_valid && exu_ready;
  assign w_lsu_hs  = lsu_valid && lsu_ready;
  assign rf_wen    = r_wen;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign wb_src    = r_src;
  assign wb_cnt    = r_wb_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exu_full <= 1'b0;
      r_lsu_full <= 1'b0;
      r_last_lsu <= 1'b0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_src      <= 1'b0;
      r_wb_cnt   <= '0;
    end else begin
      if (flush) r_exu_full <= 1'b0;
      else if (w_exu_hs) begin
        r_exu_full <= 1'b1;
        r_exu_rd   <= exu_rd;
        r_exu_res  <= exu_res;
      end else if (w_gnt_exu) r_exu_full <= 1'b0;
      if (flush) r_lsu_full <= 1'b0;
      else if (w_lsu_hs) begin
        r_lsu_full <= 1'b1;
        r_lsu_rd   <= lsu_rd;
        r_lsu_res  <= lsu_res;
      end else if (w_gnt_lsu) r_lsu_full <= 1'b0;
      r_wen <= w_wr;
      if (w_gnt) r_last_lsu <= w_gnt_lsu;
      if (w_wr) begin
        r_waddr  <= w_rd;
        r_wdata  <= w_res;
        r_src    <= w_gnt_lsu;
        r_wb_cnt <= r_wb_cnt + 32'd1;
      end
    end
  end
endmodule
